// File: rtl/bus_protocol_master_if.sv
// Bundle of upstream push and dValid/dAck bus signals for bus_protocol_master.
//   in_valid/in_data/in_ready : upstream byte push handshake
//   dValid/data/dAck          : byte bus toward the target
//   done/err_timeout/err_early: per-transfer outcome pulses
// master: the transmit block's view. slave: the producer/target/bench view.
interface bus_protocol_master_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       dValid;
  logic [7:0] data;
  logic       dAck;
  logic       done;
  logic       err_timeout;
  logic       err_early;

  modport master (
    input  in_valid, in_data, dAck,
    output in_ready, dValid, data, done, err_timeout, err_early
  );

  modport slave (
    output in_valid, in_data, dAck,
    input  in_ready, dValid, data, done, err_timeout, err_early
  );
endinterface

// File: rtl/bus_protocol_master.sv
// Transmit master for the dValid/dAck byte bus.
// Bytes pushed upstream are queued in a DEPTH-entry FIFO and sent one per bus
// transfer. dValid stays high 3..5 sampled edges: a rising dAck seen at the
// 3rd..5th high sample ends the transfer (done), otherwise it times out after
// the 5th (err_timeout). dAck high on the first two high samples is flagged
// (err_early) and ignored. At least one idle edge separates transfers.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; drops dValid, flushes the FIFO
//   bus   : bus_protocol_master_if.master (push handshake, bus, pulses)
module bus_protocol_master #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  bus_protocol_master_if.master bus
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, XFER} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop;

  state_t        state;
  logic [2:0]    vcnt;      // index of the current high sample of dValid
  logic          ack_q;     // dAck at the previous edge, for rise detection
  logic          dvalid_q, done_q, to_q, early_q;
  logic [7:0]    data_q;

  assign bus.in_ready    = (count != FULL_CNT);
  assign bus.dValid      = dvalid_q;
  assign bus.data        = data_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = to_q;
  assign bus.err_early   = early_q;

  assign push = bus.in_valid && bus.in_ready;
  // Only registered entries are popped, so a fresh push launches one edge later.
  assign pop  = (state == IDLE) && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      vcnt     <= '0;
      ack_q    <= 1'b0;
      dvalid_q <= 1'b0;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      early_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      early_q <= 1'b0;
      ack_q   <= bus.dAck;
      case (state)
        IDLE: begin
          if (pop) begin
            dvalid_q <= 1'b1;
            data_q   <= mem[rptr];
            vcnt     <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (vcnt < 3'd2) begin
            // Too early to acknowledge; report and keep the transfer going.
            if (bus.dAck) early_q <= 1'b1;
            vcnt <= vcnt + 3'd1;
          end else if (bus.dAck && !ack_q) begin
            dvalid_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= IDLE;
          end else if (vcnt == 3'd4) begin
            // Byte is dropped, not retried.
            dvalid_q <= 1'b0;
            to_q     <= 1'b1;
            state    <= IDLE;
          end else begin
            vcnt <= vcnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_protocol_master.sv
// Randomized bench for bus_protocol_master against a queue-based model of the
// bus rules. Inputs change and outputs are checked on the falling edge.
module tb_bus_protocol_master;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bus_protocol_master_if bif();

  bus_protocol_master #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pushed   = 0;

  // Model: pending bytes, current transfer, and which high sample comes next.
  byte unsigned q[$];
  bit           m_valid;
  logic [7:0]   m_data;
  int           m_k;
  bit           m_prev, m_done, m_to, m_early;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_valid = 0; m_data = 8'h00; m_k = 0;
    m_prev = 0; m_done = 0; m_to = 0; m_early = 0;
  endtask

  // One rising edge of the bus rules, with inputs v/d/a sampled at it.
  task automatic m_step(input bit v, input logic [7:0] d, input bit a);
    bit psh;
    psh = v && (q.size() < DEPTH);
    m_done = 0; m_to = 0; m_early = 0;
    if (!m_valid) begin
      if (q.size() != 0) begin
        m_data  = q.pop_front();
        m_valid = 1;
        m_k     = 0;
      end
    end else if (m_k < 2) begin
      if (a) m_early = 1;
      m_k++;
    end else if (a && !m_prev) begin
      m_valid = 0; m_done = 1;
    end else if (m_k == 4) begin
      m_valid = 0; m_to = 1;
    end else begin
      m_k++;
    end
    m_prev = a;
    if (psh) begin
      q.push_back(d);
      pushed++;
    end
  endtask

  task automatic cmp_all();
    chk("dValid",      bif.dValid,      m_valid);
    chk("data",        bif.data,        m_data);
    chk("done",        bif.done,        m_done);
    chk("err_timeout", bif.err_timeout, m_to);
    chk("err_early",   bif.err_early,   m_early);
    chk("in_ready",    bif.in_ready,    q.size() < DEPTH);
  endtask

  // Target behaviour: 0 never acks, 2..4 ack at that high sample,
  // 9 premature (1 at samples 1 and 3), 10 random, 11 held high.
  function automatic bit tgt(input int mode);
    case (mode)
      2, 3, 4: return m_valid && (m_k == mode);
      9:       return m_valid && (m_k == 1 || m_k == 3);
      10:      return 1'($urandom_range(0, 1));
      11:      return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input int mode);
    bit a;
    cmp_all();
    a = tgt(mode);
    bif.in_valid = v;
    bif.in_data  = d;
    bif.dAck     = a;
    m_step(v, d, a);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) step(0, 8'($urandom), mode);
  endtask

  initial begin
    int mode, pv, start, n;
    bit hit;
    bif.in_valid = 0; bif.in_data = 8'h00; bif.dAck = 0;
    m_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_dValid",   bif.dValid,      0);
    chk("rst_data",     bif.data,        8'h00);
    chk("rst_in_ready", bif.in_ready,    1);
    chk("rst_pulses",   {bif.done, bif.err_timeout, bif.err_early}, 0);
    reset = 0;

    // Single byte, fast ack.
    step(1, 8'hA5, 2); idle(10, 2);
    // Back-to-back three bytes, ack on the 4th high sample.
    step(1, 8'h11, 3); step(1, 8'h22, 3); step(1, 8'h33, 3); idle(20, 3);
    // Timeout, then a normal transfer.
    step(1, 8'h5C, 0); idle(8, 0);
    step(1, 8'h77, 2); idle(8, 2);
    // Premature ack.
    step(1, 8'h99, 9); idle(10, 9);
    // Level-high dAck carried across transfers is never accepted.
    step(1, 8'h3E, 11); step(1, 8'h3F, 11); idle(16, 11); idle(3, 0);
    // FIFO full with the target stalled; order through pointer wrap.
    start = pushed; n = 0;
    while (pushed - start < 6 && n < 60) begin
      step(1, 8'hE0 + 8'(pushed - start), 0);
      n++;
    end
    chk("fifo_full_bound", pushed - start, 6);
    idle(40, 3);

    // Reset two edges into a transfer with two bytes still queued.
    for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_valid && m_k == 2) hit = 1;
      else step(0, 8'h00, 0);
    end
    chk("reset_reach_bound", hit, 1);
    bif.in_valid = 0; bif.dAck = 0;
    #2 reset = 1;
    #1;
    chk("mrst_dValid",   bif.dValid,   0);
    chk("mrst_data",     bif.data,     8'h00);
    chk("mrst_in_ready", bif.in_ready, 1);
    chk("mrst_pulses",   {bif.done, bif.err_timeout, bif.err_early}, 0);
    @(negedge clk);
    chk("mrst_hold_dValid", bif.dValid, 0);
    reset = 0;
    m_reset();
    idle(6, 2);
    step(1, 8'h42, 2); idle(10, 2);

    // Random traffic under a mix of target behaviours.
    for (int b = 0; b < 60; b++) begin
      case ($urandom_range(0, 6))
        0: mode = 0;
        1: mode = 2;
        2: mode = 3;
        3: mode = 4;
        4: mode = 9;
        5: mode = 10;
        default: mode = 11;
      endcase
      pv = $urandom_range(0, 4);
      for (int i = 0; i < 50; i++)
        step($urandom_range(0, 3) < pv, 8'($urandom), mode);
    end
    idle(30, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_protocol_master.md
# bus_protocol_master

Transmit-side master for the dValid/dAck byte bus. It accepts bytes from an upstream producer into a small FIFO and launches one bus transfer per byte on `data`/`dValid`. For each transfer it waits for the target's `dAck` and releases `dValid` the cycle after the acknowledge. It enforces the bus rules on its own outputs: `dValid` held 3–5 sampled cycles, `data` stable and known while valid, and at least one idle cycle between transfers. Target misbehaviour is reported on error pulses.

## Interface

Parameters:
- `DEPTH`, default 4: input FIFO entries; power of 2, ≥2.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream byte available.
- `in_data` input 8: upstream byte.
- `in_ready` output 1: FIFO not full. A push occurs when `in_valid && in_ready` at a posedge.
- `dValid` output 1: bus data valid (registered).
- `data` output 8: bus data (registered).
- `dAck` input 1: target acknowledge.
- `done` output 1: one-cycle pulse when a transfer is acknowledged.
- `err_timeout` output 1: one-cycle pulse when a transfer ends without an acknowledge.
- `err_early` output 1: one-cycle pulse when `dAck` is high too early in a transfer.

## Operation

- Reset values: `dValid` 0, `data` 8'h00, `done`/`err_*` 0, FIFO empty, `in_ready` 1, state IDLE, `vcnt` 0.
- `reset` asserted mid-transfer drops `dValid` immediately and discards all queued bytes. No pulse is generated.
- FIFO:
  - `in_ready = !full`.
  - No bypass: a byte pushed at edge E can launch at edge E+1 at the earliest.
  - Push and pop in the same edge are both honoured.
  - Pointers wrap modulo `DEPTH`. The occupancy count is `$clog2(DEPTH)+1` bits.
- State machine IDLE / XFER:
  - **IDLE**, FIFO non-empty: at the edge, `dValid<=1`, `data<=head`, pop, `vcnt<=0`, go to XFER.
  - **XFER**: `vcnt` counts posedges at which `dValid` is sampled high. The launch-following edge T (where `$rose(dValid)` is seen) is `vcnt`=0.
  - `dAck` sampled high at edge T or T+1 (`vcnt` 0 or 1): pulse `err_early`. The transfer continues and that sample is not an acknowledge.
  - Acknowledge accepted at edges T+2..T+4 (`vcnt` 2..4) only on a rising `dAck`, i.e. `dAck`=1 and previous sample 0. On acknowledge: `dValid<=0`, `done<=1`, go to IDLE.
  - Timeout: at edge T+4 with no accepted acknowledge: `dValid<=0`, `err_timeout<=1`, go to IDLE. The byte is dropped, not retried.
- `data` is loaded only on launch. It holds its value through the transfer and after `dValid` falls, until the next launch, so it is never X after reset.
- A level-high `dAck` carried over from a previous transfer is not a rising edge and is never accepted.

## Timing

- `dValid` is high for 3, 4 or 5 sampled edges: ack at T+2 / T+3 / T+4 means fall seen at T+3 / T+4 / T+5. This satisfies "high 2..4 clocks after rise, then fall".
- `done` and `err_timeout` are high during the cycle after the deciding edge, coincident with `dValid` low.
- Minimum gap: in IDLE after the fall, relaunch is at the first IDLE edge. `dValid` is therefore sampled low for exactly 1 edge between back-to-back transfers.
- Latency from a push into an empty idle FIFO at edge E: `dValid` high after edge E+1, and `$rose` is seen at E+2.
- Throughput: at best one byte per 4 clocks (3 high + 1 low).

## Test plan

- **Single byte, fast ack.** Push 8'hA5; target raises `dAck` so it is sampled at T+2. Required: `data`=A5 stable T..T+2, `dValid` falls at T+3, `done` pulses once, FIFO empty.
- **Back-to-back, three bytes.** Push 11, 22, 33 while idle; ack at T+3 each time. Required: three transfers in order, each `dValid` high 4 edges, exactly one low edge between them, `in_ready` stays 1.
- **Timeout.** Push 8'h5C; `dAck` held 0. Required: `dValid` high T..T+4 and low at T+5, `err_timeout` pulses, `done` stays 0, next byte launches normally.
- **Premature ack.** `dAck`=1 at T+1, 0 at T+2, 1 at T+3. Required: `err_early` pulses once, acknowledge accepted at T+3, `dValid` low at T+4, `done` pulses.
- **FIFO full.** With `DEPTH`=4, hold the target in timeout and push 6 bytes. Required: `in_ready` drops after the 4th pending entry. Byte 5 is accepted only after a pop. Order is preserved through pointer wrap.
- **Reset mid-transfer.** Assert `reset` at T+2 with 2 bytes queued. Required: `dValid`=0 and `data`=00 immediately, no pulses, `in_ready`=1, no launch until new pushes arrive after reset is released.
